// File: rtl/bm_dl_shared_adder_arbiter_pkg.sv
// Shared definitions for the adder microbenchmarks.
//   SliceW  : width of the time-shared adder slice (one nibble).
//   state_e : sequencing states for the shared-adder FSM.
package bm_dl_shared_adder_arbiter_pkg;

    localparam int unsigned SliceW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/bm_dl_shared_adder_arbiter_nibble_adder.sv
// Purely combinational ripple-carry adder slice, one nibble wide.
//   cin  : carry in
//   x, y : nibble operands
//   s    : nibble sum
//   cout : carry out of the top bit
module nibble_adder
    import bm_dl_shared_adder_arbiter_pkg::*;
(
    input  logic              cin,
    input  logic [SliceW-1:0] x,
    input  logic [SliceW-1:0] y,
    output logic [SliceW-1:0] s,
    output logic              cout
);

    always_comb begin : ripple
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < SliceW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/bm_dl_shared_adder_arbiter.sv
// Two-requester round-robin arbiter in front of a single nibble adder slice.
// A granted operation takes NIBBLES cycles (LSB nibble first) plus one IDLE
// and one DONE cycle.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   reqN, aN, bN, cinN  : requester N request and operands (N = 0, 1)
//   gnt0, gnt1          : one-cycle grant pulse, first RUN cycle
//   busy                : high in RUN and DONE
//   done, done_id       : one-cycle result-valid pulse and result owner
//   sum, cout           : result, held until the next completion
module bm_dl_shared_adder_arbiter
    import bm_dl_shared_adder_arbiter_pkg::*;
#(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = SliceW * NIBBLES
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         cin0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic         cin1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic         done_id,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned     IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, b_q, acc_q, acc_d, sum_q;
    logic [IdxW-1:0]   idx_q;
    logic              carry_q, cout_q, owner_q, last_q, gnt0_q, gnt1_q;
    logic              any_req, winner, last_nib;
    logic [SliceW-1:0] x_nib, y_nib, s_nib;
    logic              slice_cout;

    nibble_adder u_slice (
        .cin  (carry_q),
        .x    (x_nib),
        .y    (y_nib),
        .s    (s_nib),
        .cout (slice_cout)
    );

    always_comb begin
        any_req  = req0 | req1;
        // On a tie the requester not served last wins; otherwise the lone one.
        winner   = (req0 & req1) ? ~last_q : req1;
        last_nib = (idx_q == LastIdx);
        x_nib    = a_q[idx_q*SliceW +: SliceW];
        y_nib    = b_q[idx_q*SliceW +: SliceW];
        acc_d    = acc_q;
        acc_d[idx_q*SliceW +: SliceW] = s_nib;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StRun;
            StRun:   if (last_nib) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        gnt0_q  <= ~winner;
                        gnt1_q  <= winner;
                        owner_q <= winner;
                        last_q  <= winner;
                        a_q     <= winner ? a1 : a0;
                        b_q     <= winner ? b1 : b0;
                        carry_q <= winner ? cin1 : cin0;
                        idx_q   <= '0;
                    end
                end
                StRun: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    // Visible result only changes on entry to DONE.
                    if (last_nib) begin
                        sum_q  <= acc_d;
                        cout_q <= slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign done_id = owner_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_bm_dl_shared_adder_arbiter.sv
module tb_bm_dl_shared_adder_arbiter;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clock = 1'b0;
    logic         reset;
    logic         req0, req1, cin0, cin1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, done, done_id, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    bm_dl_shared_adder_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clock   (clock),
        .reset   (reset),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .cin0    (cin0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .cin1    (cin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called in the grant cycle; walks to the DONE cycle and checks the result.
    task automatic finish_op(input string tag, input logic [W-1:0] es, input logic ec,
                             input logic eid);
        for (int i = 1; i < NIBBLES; i++) begin
            tick();
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
            chk({tag, "_nogrant"}, {30'd0, gnt1, gnt0}, 32'd0);
        end
        tick();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({tag, "_id"}, {31'd0, done_id}, {31'd0, eid});
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0FCD; cin0 = 1'b0;
        req1 = 1'b0; a1 = 16'h0000; b1 = 16'h0000; cin1 = 1'b0;

        // Reset held two cycles with req0 high.
        tick();
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_id", {31'd0, done_id}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        tick();
        chk("rst2_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst2_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // Single request; operands and a busy-time req1 must not matter.
        tick();
        chk("single_gnt0", {31'd0, gnt0}, 32'd1);
        chk("single_gnt1", {31'd0, gnt1}, 32'd0);
        chk("single_busy", {31'd0, busy}, 32'd1);
        req0 = 1'b0; a0 = 16'hDEAD; b0 = 16'hBEEF; cin0 = 1'b1;
        req1 = 1'b1; a1 = 16'h5555;
        finish_op("single", 16'h2201, 1'b0, 1'b0);
        req1 = 1'b0;
        tick();
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("idle_hold", {16'd0, sum}, 32'h2201);

        // Carry ripples through all nibbles.
        req0 = 1'b1; a0 = 16'hFFFF; b0 = 16'h0000; cin0 = 1'b1;
        tick();
        chk("carry_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        finish_op("carry", 16'h0000, 1'b1, 1'b0);
        tick();

        // Tie right after reset: req0 first, then req1.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("tie_rst_sum", {16'd0, sum}, 32'd0);
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; cin0 = 1'b0;
        req1 = 1'b1; a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b0;
        tick();
        chk("tie_gnt0", {31'd0, gnt0}, 32'd1);
        chk("tie_gnt1_lo", {31'd0, gnt1}, 32'd0);
        req0 = 1'b0;
        finish_op("tie0", 16'h0003, 1'b0, 1'b0);
        tick();
        chk("tie_idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("tie_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("tie_gnt1", {31'd0, gnt1}, 32'd1);
        chk("tie_gnt0_lo", {31'd0, gnt0}, 32'd0);
        req1 = 1'b0;
        finish_op("tie1", 16'h0000, 1'b1, 1'b1);
        tick();

        // Fairness: both held high, grants alternate with fixed spacing.
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (!(gnt0 | gnt1) && cnt < 20);
            chk("fair_gap", cnt, (k == 0) ? 32'd1 : NIBBLES + 2);
            chk("fair_gnt1", {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("fair_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int i = 0; i < NIBBLES + 1; i++) tick();
        chk("fair_end_busy", {31'd0, busy}, 32'd0);

        // Reset in RUN at idx 2 aborts without a done pulse.
        req0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0;
        tick();
        chk("abort_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            tick();
            chk("abort_nodone", {30'd0, busy, done}, 32'd0);
        end
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0001; cin0 = 1'b0;
        tick();
        chk("rerun_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0;
        finish_op("rerun", 16'h0002, 1'b0, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
